// File: rtl/fir_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_display_ctrl: holds a captured FIR sample (or window peak) on HEX1/0 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_display_ctrl #(
  parameter int DATA_W         = 16,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              peak_mode,
  input  logic              byte_sel,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic              ledg
);

  localparam int              CNT_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [6:0]      c_SEG_ZERO = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   disp_d, disp_q;
  logic [DATA_W-1:0]   win_max_d, win_max_q;
  logic [CNT_W-1:0]    hold_cnt_d, hold_cnt_q;
  logic                ledg_d, ledg_q;
  logic [6:0]          hex0_d, hex0_q, hex1_d, hex1_q;
  logic [7:0]          w_byte;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0:    c = 7'h40;
      4'h1:    c = 7'h79;
      4'h2:    c = 7'h24;
      4'h3:    c = 7'h30;
      4'h4:    c = 7'h19;
      4'h5:    c = 7'h12;
      4'h6:    c = 7'h02;
      4'h7:    c = 7'h78;
      4'h8:    c = 7'h00;
      4'h9:    c = 7'h10;
      4'hA:    c = 7'h08;
      4'hB:    c = 7'h03;
      4'hC:    c = 7'h46;
      4'hD:    c = 7'h21;
      4'hE:    c = 7'h06;
      default: c = 7'h0E;
    endcase
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    win_max_d  = win_max_q;
    hold_cnt_d = hold_cnt_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (data_valid) begin
            disp_d     = data_in;
            win_max_d  = data_in;
            hold_cnt_d = c_LOAD;
            state_d    = ST_HOLD;
          end
        end
        default: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
            if (peak_mode && data_valid && ($signed(data_in) > $signed(win_max_q)))
              win_max_d = data_in;
          end else begin
            // Terminal cycle: any valid sample here is deliberately discarded.
            if (peak_mode)
              disp_d = win_max_q;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
    ledg_d = enable ? (state_d == ST_HOLD) : ledg_q;
  end

  // The hex path tracks disp_q every cycle, independent of enable.
  assign w_byte = byte_sel ? disp_q[15:8] : disp_q[7:0];
  assign hex1_d = seg(w_byte[7:4]);
  assign hex0_d = seg(w_byte[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      disp_q     <= '0;
      win_max_q  <= '0;
      hold_cnt_q <= '0;
      ledg_q     <= 1'b0;
      hex0_q     <= c_SEG_ZERO;
      hex1_q     <= c_SEG_ZERO;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      win_max_q  <= win_max_d;
      hold_cnt_q <= hold_cnt_d;
      ledg_q     <= ledg_d;
      hex0_q     <= hex0_d;
      hex1_q     <= hex1_d;
    end
  end

  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign ledg = ledg_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_display_ctrl: vector table, corner sequences and random vs model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_display_ctrl;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst, enable, data_valid, peak_mode, byte_sel;
  logic [15:0] data_in;
  logic [6:0]  hex0, hex1;
  logic        ledg;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fir_display_ctrl #(.DATA_W(16), .HOLD_CYCLES(HOLD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .peak_mode(peak_mode), .byte_sel(byte_sel), .hex0(hex0), .hex1(hex1), .ledg(ledg)
  );

  logic [6:0] seg_tab [16];

  // Reference: a window is "open" for HOLD enabled cycles after the capture.
  bit          m_open;
  int          m_age;
  logic [15:0] m_shown, m_max;
  logic [6:0]  m_hex1, m_hex0;
  logic        m_led;

  task automatic model_step();
    logic [7:0] b;
    if (rst) begin
      m_open = 0; m_age = 0; m_shown = '0; m_max = '0;
      m_hex1 = seg_tab[0]; m_hex0 = seg_tab[0]; m_led = 0;
      return;
    end
    b = byte_sel ? m_shown[15:8] : m_shown[7:0];
    m_hex1 = seg_tab[b[7:4]];
    m_hex0 = seg_tab[b[3:0]];
    if (!enable) return;
    if (!m_open) begin
      if (data_valid) begin
        m_open = 1; m_age = 0; m_shown = data_in; m_max = data_in;
      end
    end else if (m_age == HOLD - 1) begin
      if (peak_mode) m_shown = m_max;
      m_open = 0;
    end else begin
      m_age++;
      if (peak_mode && data_valid && ($signed(data_in) > $signed(m_max))) m_max = data_in;
    end
    m_led = m_open;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle(input logic r, input logic e, input logic v, input logic [15:0] d,
                       input logic p, input logic b);
    rst = r; enable = e; data_valid = v; data_in = d; peak_mode = p; byte_sel = b;
    @(posedge clk);
    model_step();
    #1;
    check("model", {17'd0, hex1, hex0, ledg}, {17'd0, m_hex1, m_hex0, m_led});
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 16'h0, p, 0);
  endtask

  typedef struct {
    logic r, e, v; logic [15:0] d; logic p, b;
    logic [6:0] h1, h0; logic l;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int led_cnt;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    tbl[0] = '{1, 1, 0, 16'h0000, 0, 0, 7'h40, 7'h40, 0};
    tbl[1] = '{1, 1, 0, 16'h0000, 0, 0, 7'h40, 7'h40, 0};
    tbl[2] = '{0, 1, 0, 16'h0000, 0, 0, 7'h40, 7'h40, 0};
    tbl[3] = '{0, 1, 1, 16'h12AB, 0, 0, 7'h40, 7'h40, 1};
    tbl[4] = '{0, 1, 0, 16'h0000, 0, 0, 7'h08, 7'h03, 1};
    tbl[5] = '{0, 1, 0, 16'h0000, 0, 0, 7'h08, 7'h03, 1};
    tbl[6] = '{0, 1, 0, 16'h0000, 0, 0, 7'h08, 7'h03, 1};
    tbl[7] = '{0, 1, 0, 16'h0000, 0, 0, 7'h08, 7'h03, 0};
    tbl[8] = '{0, 1, 0, 16'h0000, 0, 1, 7'h79, 7'h24, 0};
    tbl[9] = '{0, 1, 0, 16'h0000, 0, 1, 7'h79, 7'h24, 0};

    cycle(1, 1, 0, 16'h0, 0, 0);
    cycle(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 16'h0, 0, 0);
      check("reset_idle", {17'd0, hex1, hex0, ledg}, {17'd0, 7'h40, 7'h40, 1'b0});
    end

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].b);
      check($sformatf("vec%0d", i), {17'd0, hex1, hex0, ledg},
            {17'd0, tbl[i].h1, tbl[i].h0, tbl[i].l});
    end

    // Non-peak: second sample inside the window is dropped.
    cycle(0, 1, 1, 16'h0001, 0, 0);
    cycle(0, 1, 1, 16'h0002, 0, 0);
    idle(6, 0);
    check("nonpeak_hold", {hex1, hex0}, {7'h40, 7'h79});
    cycle(0, 1, 1, 16'h0002, 0, 0);
    idle(1, 0);
    check("nonpeak_resend", {hex1, hex0}, {7'h40, 7'h24});
    idle(6, 0);

    // Peak mode, signed maximum.
    cycle(0, 1, 1, 16'h0005, 1, 0);
    cycle(0, 1, 1, 16'hFFF0, 1, 0);
    cycle(0, 1, 1, 16'h0030, 1, 0);
    idle(5, 1);
    check("peak_pos", {hex1, hex0}, {7'h30, 7'h40});
    cycle(0, 1, 1, 16'hFFF0, 1, 0);
    cycle(0, 1, 1, 16'hFFE0, 1, 0);
    idle(6, 1);
    check("peak_neg", {hex1, hex0}, {7'h0E, 7'h40});

    // Freeze mid-window: valid samples during enable=0 must be lost.
    led_cnt = 0;
    cycle(0, 1, 1, 16'h00C3, 1, 0); led_cnt += ledg;
    cycle(0, 1, 0, 16'h0000, 1, 0); led_cnt += ledg;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 16'h7FFF, 1, 0); led_cnt += ledg;
    end
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 0, 16'h0000, 1, 0); led_cnt += ledg;
    end
    check("freeze_led_len", led_cnt, 7);
    check("freeze_display", {hex1, hex0}, {7'h46, 7'h30});

    // Reset in the middle of a window.
    cycle(0, 1, 1, 16'h5555, 0, 0);
    idle(2, 0);
    cycle(1, 1, 0, 16'h0000, 0, 0);
    check("rst_midhold", {hex1, hex0, ledg}, {7'h40, 7'h40, 1'b0});

    // Valid on the terminal cycle is dropped; the next one is captured.
    cycle(0, 1, 1, 16'h00AA, 0, 0);
    idle(3, 0);
    cycle(0, 1, 1, 16'h0055, 0, 0);
    check("term_led", ledg, 1'b0);
    cycle(0, 1, 1, 16'h0066, 0, 0);
    check("recapture", {hex1, hex0, ledg}, {7'h08, 7'h08, 1'b1});
    idle(1, 0);
    check("recapture_hex", {hex1, hex0}, {7'h02, 7'h02});
    idle(6, 0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 2), ($urandom_range(99) < 85), ($urandom_range(99) < 35),
            16'($urandom), ($urandom_range(99) < 50), ($urandom_range(99) < 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
